// File: rtl/pipe_mux_n_pkg.sv
// Shared definitions for the pipe_mux_n selector: select-width derivation,
// skid-buffer state encoding and error-counter width.
package pipe_mux_n_pkg;

  // Encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } buf_state_e;

  localparam int ERRCNT_W = 8;

  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush; in_ready is
// derived from registered occupancy only, never from out_ready.
module pipe_skid_buf
  import pipe_mux_n_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  buf_state_e   state_q, state_d;
  logic [W-1:0] main_q, skid_q;
  logic         accept, fire;
  logic         load_main_in, load_main_skid, load_skid;

  assign in_ready  = (state_q != ST_FULL) && !rst;
  assign out_valid = (state_q == ST_ONE) || (state_q == ST_FULL);
  assign out_data  = main_q;
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (accept) begin
          state_d      = ST_ONE;
          load_main_in = 1'b1;
        end
        ST_ONE: begin
          if (accept && fire) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
          end else if (fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: if (fire) begin
          state_d        = ST_ONE;
          load_main_skid = 1'b1;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      // NOTE: data entries are reset because the visible out_data must read
      // zero after reset, not just the valid bits.
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main_in)        main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end

endmodule

// File: rtl/pipe_mux_n.sv
// N-input WIDTH-bit selector feeding a registered skid-buffer output stage.
// Optional macro PIPE_MUX_ERRCNT_EN adds a saturating bad-select counter err_cnt.
module pipe_mux_n
  import pipe_mux_n_pkg::*;
#(
  parameter  int N_IN  = 4,
  parameter  int WIDTH = 32,
  localparam int SEL_W = sel_w(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sel_err
`ifdef PIPE_MUX_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0]   err_cnt
`endif
);

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic [WIDTH:0]   buf_out;

  always_comb begin
    sel_data = '0;
    sel_err  = (int'(in_sel) >= N_IN);
    for (int k = 0; k < N_IN; k++) begin
      if (in_sel == SEL_W'(k)) sel_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  // The error flag travels with its data so both leave the buffer together.
  pipe_skid_buf #(
    .W(WIDTH + 1)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_data  ({sel_err, sel_data}),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (buf_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign out_data    = buf_out[WIDTH-1:0];
  assign out_sel_err = buf_out[WIDTH];

`ifdef PIPE_MUX_ERRCNT_EN
  // Counts every accepted bad select, including beats dropped by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (in_valid && in_ready && sel_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERRCNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_mux_n.sv
// Self-checking bench: a 4-input and a 3-input pipe_mux_n share all stimulus and
// are compared against a queue-based occupancy/ordering model.
module tb_pipe_mux_n;

  typedef struct packed {
    logic [1:0]       sel;
    logic [3:0][31:0] d;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [1:0]       in_sel = '0;
  logic [3:0][31:0] chan = '0;

  logic        in_ready4, out_valid4, out_sel_err4;
  logic        in_ready3, out_valid3, out_sel_err3;
  logic [31:0] out_data4, out_data3;
`ifdef PIPE_MUX_ERRCNT_EN
  logic [7:0]  err_cnt4, err_cnt3;
`endif

  int    checks = 0;
  int    errors = 0;
  beat_t q[$];
  beat_t last_head = '0;
  int    cnt3 = 0;

  always #5 clk = ~clk;

  pipe_mux_n #(.N_IN(4), .WIDTH(32)) dut4 (
    .clk(clk), .rst(rst), .in_data(chan), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready4), .flush(flush), .out_data(out_data4), .out_valid(out_valid4),
    .out_ready(out_ready), .out_sel_err(out_sel_err4)
`ifdef PIPE_MUX_ERRCNT_EN
    , .err_cnt(err_cnt4)
`endif
  );

  pipe_mux_n #(.N_IN(3), .WIDTH(32)) dut3 (
    .clk(clk), .rst(rst), .in_data(chan[2:0]), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready3), .flush(flush), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready), .out_sel_err(out_sel_err3)
`ifdef PIPE_MUX_ERRCNT_EN
    , .err_cnt(err_cnt3)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_d(input beat_t b, input int n);
    return (int'(b.sel) < n) ? b.d[b.sel] : 32'h0;
  endfunction

  task automatic verify(input bit stable, input logic [31:0] p4, input logic [31:0] p3);
    bit    ev;
    beat_t h;
    ev = (q.size() > 0);
    h  = ev ? q[0] : last_head;
    check("in_ready4", in_ready4, !rst && (q.size() < 2));
    check("in_ready3", in_ready3, !rst && (q.size() < 2));
    check("out_valid4", out_valid4, ev);
    check("out_valid3", out_valid3, ev);
    check("out_data4", out_data4, exp_d(h, 4));
    check("out_data3", out_data3, exp_d(h, 3));
    if (ev) begin
      check("sel_err4", out_sel_err4, 1'b0);
      check("sel_err3", out_sel_err3, int'(h.sel) >= 3);
    end
    if (stable) begin
      check("stable4", out_data4, p4);
      check("stable3", out_data3, p3);
    end
`ifdef PIPE_MUX_ERRCNT_EN
    check("err_cnt3", err_cnt3, cnt3);
`endif
  endtask

  // Drives one cycle from a negedge, advances the model at the posedge and
  // verifies at the following negedge.
  task automatic step(input logic v, input logic [1:0] s, input logic ordy,
                      input logic fl, output bit acc);
    bit          fir, stable;
    logic [31:0] p4, p3;
    beat_t       b;
    stable    = out_valid4 && !ordy && !fl && !rst;
    p4        = out_data4;
    p3        = out_data3;
    in_valid  = v;
    in_sel    = s;
    out_ready = ordy;
    flush     = fl;
    acc       = v && !rst && (q.size() < 2);
    fir       = ordy && (q.size() > 0);
    b.sel     = s;
    b.d       = chan;
    @(posedge clk);
    if (rst) begin
      q.delete();
      last_head = '0;
      cnt3      = 0;
    end else begin
      if (acc && s == 2'd3 && cnt3 < 255) cnt3++;
      if (fl) q.delete();
      else begin
        if (fir) void'(q.pop_front());
        if (acc) q.push_back(b);
      end
      if (q.size() > 0) last_head = q[0];
    end
    @(negedge clk);
    verify(stable, p4, p3);
  endtask

  initial begin
    bit          a;
    bit          o;
    int          cyc;
    logic [31:0] got[$];

    rst = 1'b1;
    step(0, 0, 0, 0, a);
    step(0, 0, 0, 0, a);
    check("rst_in_ready", in_ready4, 1'b0);
    check("rst_out_data", out_data4, 32'h0);
    rst  = 1'b0;
    chan = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    // single beat, sel=2
    step(1, 2'd2, 1, 0, a);
    check("t1_data", out_data4, 32'h33333333);
    check("t1_valid", out_valid4, 1'b1);
    check("t1_err", out_sel_err4, 1'b0);
    step(0, 0, 1, 0, a);

    // back-to-back with a 3-cycle downstream stall
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      a = 1'b0;
      while (!a && cyc < 50) begin
        o = (cyc >= 3);
        if (out_valid4 && o) got.push_back(out_data4);
        step(1, 2'(i), o, 0, a);
        cyc++;
        if (a && i == 1) check("t2_ready_drop", in_ready4, 1'b0);
      end
    end
    repeat (4) begin
      if (out_valid4) got.push_back(out_data4);
      step(0, 0, 1, 0, a);
    end
    check("t2_count", got.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < got.size()) check("t2_order", got[k], chan[k]);
    end

    // bad select on the 3-input instance
    rst = 1'b1;
    step(0, 0, 0, 0, a);
    rst = 1'b0;
    step(1, 2'd3, 1, 0, a);
    check("t3_data3", out_data3, 32'h0);
    check("t3_err3", out_sel_err3, 1'b1);
    check("t3_data4", out_data4, 32'h44444444);
`ifdef PIPE_MUX_ERRCNT_EN
    check("t3_cnt1", err_cnt3, 8'd1);
    repeat (300) step(1, 2'd3, 1, 0, a);
    check("t3_cnt_sat", err_cnt3, 8'd255);
    check("t3_cnt4", err_cnt4, 8'd0);
`endif
    step(0, 0, 1, 0, a);

    // flush from FULL, then from ONE with a beat being accepted
    step(1, 2'd0, 0, 0, a);
    step(1, 2'd1, 0, 0, a);
    check("t4_full", in_ready4, 1'b0);
    step(1, 2'd2, 0, 1, a);
    check("t4_valid", out_valid4, 1'b0);
    check("t4_ready", in_ready4, 1'b1);
    check("t4_hold", out_data4, 32'h11111111);
    step(0, 0, 1, 0, a);
    step(1, 2'd0, 0, 0, a);
    step(1, 2'd3, 1, 1, a);
    check("t4_drop", out_valid4, 1'b0);
    step(0, 0, 1, 0, a);
    step(0, 0, 1, 0, a);

    // reset while FULL and stalled
    step(1, 2'd2, 0, 0, a);
    step(1, 2'd3, 0, 0, a);
    rst = 1'b1;
    step(0, 0, 0, 0, a);
    check("t5_valid", out_valid4, 1'b0);
    check("t5_data", out_data4, 32'h0);
    check("t5_ready", in_ready4, 1'b0);
    step(1, 2'd1, 0, 0, a);
    check("t5_ready_hold", in_ready4, 1'b0);
    rst = 1'b0;
    step(1, 2'd1, 1, 0, a);
    check("t5_first", out_data4, 32'h22222222);
    check("t5_first_valid", out_valid4, 1'b1);
    step(0, 0, 1, 0, a);

    // randomized traffic
    repeat (10000) begin
      for (int k = 0; k < 4; k++) chan[k] = $urandom;
      rst = ($urandom_range(0, 511) == 0);
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0), a);
    end
    rst = 1'b0;
    step(0, 0, 1, 0, a);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
